// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if
//   Groups the serial input line and the host-side receive outputs of
//   uart_rx_param into one bundle.
//   Signals:
//     iRx        serial line, idle high (driven by the line side)
//     oData      last received word, DATA_BITS wide
//     oValid     one-cycle strobe marking a new word and new error flags
//     oParityErr parity mismatch on the last frame
//     oFrameErr  a stop bit was sampled low on the last frame
//     oBusy      receiver is inside a frame
//   Modports:
//     slave  - the receiver (consumes iRx, drives the outputs)
//     master - the line/host side (drives iRx, consumes the outputs)
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 iRx;
    logic [DATA_BITS-1:0] oData;
    logic                 oValid;
    logic                 oParityErr;
    logic                 oFrameErr;
    logic                 oBusy;

    modport slave (
        input  iRx,
        output oData,
        output oValid,
        output oParityErr,
        output oFrameErr,
        output oBusy
    );

    modport master (
        output iRx,
        input  oData,
        input  oValid,
        input  oParityErr,
        input  oFrameErr,
        input  oBusy
    );
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param
//   Parametrised UART receiver. Converts the asynchronous serial line into
//   parallel words using mid-bit sampling, with start-bit glitch rejection,
//   optional even/odd parity, 1 or 2 stop bits, parity/framing error flags
//   and break handling (a frame ending in a low stop bit blocks further
//   reception until the line has been seen high again).
//   Ports:
//     iClk  system clock, rising edge
//     iRst  asynchronous active-high reset
//     bus   uart_rx_param_if.slave: iRx in; oData, oValid, oParityErr,
//           oFrameErr, oBusy out (all outputs registered)
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic          iClk,
    input  logic          iRst,
    uart_rx_param_if.slave bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int IDX_W = 4;

    localparam logic [CNT_W-1:0] CNT_HALF      = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_err_pend;
    logic                 frm_err_pend;
    logic                 brk;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 busy_q;

    // Parity bit the transmitter should have sent for a given word.
    function automatic logic exp_parity(input logic [DATA_BITS-1:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    // Two-flop synchroniser; resets to the idle-high line level so that
    // reset release never looks like a start edge.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.iRx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift_reg    <= '0;
            par_err_pend <= 1'b0;
            frm_err_pend <= 1'b0;
            brk          <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (brk) begin
                        // Line still held low after a break: ignore it until it
                        // has gone high, otherwise it would re-trigger forever.
                        if (rx_s) brk <= 1'b0;
                    end else if (!rx_s) begin
                        state  <= S_START;
                        busy_q <= 1'b1;
                    end
                end

                S_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state        <= S_DATA;
                            bit_idx      <= '0;
                            par_err_pend <= 1'b0;
                            frm_err_pend <= 1'b0;
                        end else begin
                            // Start bit gone by its midpoint: treat as a glitch.
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        if (bit_idx == IDX_DATA_LAST) begin
                            bit_idx <= '0;
                            state   <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt          <= '0;
                        par_err_pend <= (rx_s != exp_parity(shift_reg));
                        state        <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (bit_idx == IDX_STOP_LAST) begin
                            // Leave mid-way through the last stop bit so a
                            // start edge right after it is not missed.
                            bit_idx <= '0;
                            state   <= S_IDLE;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b1;
                            data_q  <= shift_reg;
                            perr_q  <= par_err_pend;
                            ferr_q  <= frm_err_pend | !rx_s;
                            brk     <= !rx_s;
                        end else begin
                            frm_err_pend <= frm_err_pend | !rx_s;
                            bit_idx      <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

    assign bus.oData      = data_q;
    assign bus.oValid     = valid_q;
    assign bus.oParityErr = perr_q;
    assign bus.oFrameErr  = ferr_q;
    assign bus.oBusy      = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param
//   Directed bench for uart_rx_param. Three receivers share clock and reset:
//     dut0: 16 clks/bit, 8 data bits, even parity, 1 stop bit
//     dut1: 16 clks/bit, 7 data bits, no parity, 2 stop bits
//     dut2: 16 clks/bit, 8 data bits, odd parity, 1 stop bit
//   Each has its own serial line so frames for one never disturb another.
module tb_uart_rx_param;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    // From the start-bit fall to the strobe: two synchroniser flops, one
    // IDLE detect cycle, half a bit to the start midpoint, then one bit
    // period per remaining bit up to the last stop-bit midpoint.
    localparam int LAT0 = 3 + HALF + (8 + 1 + 1) * CPB;
    localparam int LAT1 = 3 + HALF + (7 + 0 + 2) * CPB;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } rec_t;

    logic       iClk = 1'b0;
    logic       iRst;
    logic [2:0] rx_line;
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         start_cyc = 0;
    rec_t       q0[$];
    rec_t       q1[$];
    rec_t       q2[$];
    rec_t       r0, r1, r2;

    always #5 iClk = ~iClk;
    always @(posedge iClk) cyc <= cyc + 1;

    uart_rx_param_if #(.DATA_BITS(8)) bus0 ();
    uart_rx_param_if #(.DATA_BITS(7)) bus1 ();
    uart_rx_param_if #(.DATA_BITS(8)) bus2 ();

    assign bus0.iRx = rx_line[0];
    assign bus1.iRx = rx_line[1];
    assign bus2.iRx = rx_line[2];

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1),
                    .PARITY_ODD(0), .STOP_BITS(1))
        dut0 (.iClk(iClk), .iRst(iRst), .bus(bus0));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(0),
                    .PARITY_ODD(0), .STOP_BITS(2))
        dut1 (.iClk(iClk), .iRst(iRst), .bus(bus1));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1),
                    .PARITY_ODD(1), .STOP_BITS(1))
        dut2 (.iClk(iClk), .iRst(iRst), .bus(bus2));

    // Strobe monitors: record every word with the cycle it appeared.
    always @(negedge iClk) begin
        if (bus0.oValid === 1'b1) begin
            r0.data = 9'(bus0.oData);
            r0.perr = bus0.oParityErr;
            r0.ferr = bus0.oFrameErr;
            r0.cyc  = cyc;
            q0.push_back(r0);
        end
        if (bus1.oValid === 1'b1) begin
            r1.data = 9'(bus1.oData);
            r1.perr = bus1.oParityErr;
            r1.ferr = bus1.oFrameErr;
            r1.cyc  = cyc;
            q1.push_back(r1);
        end
        if (bus2.oValid === 1'b1) begin
            r2.data = 9'(bus2.oData);
            r2.perr = bus2.oParityErr;
            r2.ferr = bus2.oFrameErr;
            r2.cyc  = cyc;
            q2.push_back(r2);
        end
    end

    task automatic drive_bit(input int sel, input logic b);
        rx_line[sel] = b;
        repeat (CPB) @(posedge iClk);
        #1;
    endtask

    // Sends start, data LSB first, optional parity, then stop bits; the
    // last stop bit takes last_stop and the line is left at that level.
    task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                              input bit has_par, input logic par_bit,
                              input int nstop, input logic last_stop);
        start_cyc = cyc;
        drive_bit(sel, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(sel, data[i]);
        if (has_par) drive_bit(sel, par_bit);
        for (int i = 0; i < nstop; i++) drive_bit(sel, (i == nstop - 1) ? last_stop : 1'b1);
    endtask

    task automatic idle_bits(input int n);
        repeat (n * CPB) @(posedge iClk);
        #1;
    endtask

    task automatic test_reset();
        iRst    = 1'b1;
        rx_line = 3'b111;
        repeat (3) @(negedge iClk);
        total++; if (bus0.oData !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", bus0.oData); end
        total++; if (bus0.oValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus0.oValid); end
        total++; if (bus0.oParityErr !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b want=0", bus0.oParityErr); end
        total++; if (bus0.oFrameErr !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", bus0.oFrameErr); end
        total++; if (bus0.oBusy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus0.oBusy); end
        @(posedge iClk); #1;
        iRst = 1'b0;
        idle_bits(2);
    endtask

    task automatic test_single();
        int lat;
        q0.delete();
        send_frame(0, 9'h0A5, 8, 1'b1, 1'b0, 1, 1'b1);
        idle_bits(2);
        total++; if (q0.size() !== 1) begin bad++; $display("FAIL single_count got=%0d want=1", q0.size()); end
        if (q0.size() > 0) begin
            total++; if (q0[0].data !== 9'h0A5) begin bad++; $display("FAIL single_data got=%h want=0a5", q0[0].data); end
            total++; if (q0[0].perr !== 1'b0) begin bad++; $display("FAIL single_perr got=%b want=0", q0[0].perr); end
            total++; if (q0[0].ferr !== 1'b0) begin bad++; $display("FAIL single_ferr got=%b want=0", q0[0].ferr); end
            lat = q0[0].cyc - start_cyc;
            total++; if (lat < LAT0 - 1 || lat > LAT0 + 1) begin bad++; $display("FAIL single_latency got=%0d want=%0d+-1", lat, LAT0); end
        end
        total++; if (bus0.oBusy !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b want=0", bus0.oBusy); end
    endtask

    task automatic test_parity_err();
        q0.delete();
        send_frame(0, 9'h001, 8, 1'b1, 1'b0, 1, 1'b1);
        idle_bits(1);
        total++; if (q0.size() !== 1) begin bad++; $display("FAIL perr_count got=%0d want=1", q0.size()); end
        total++; if (bus0.oData !== 8'h01) begin bad++; $display("FAIL perr_data got=%h want=01", bus0.oData); end
        total++; if (bus0.oParityErr !== 1'b1) begin bad++; $display("FAIL perr_flag got=%b want=1", bus0.oParityErr); end
        total++; if (bus0.oFrameErr !== 1'b0) begin bad++; $display("FAIL perr_ferr got=%b want=0", bus0.oFrameErr); end
        send_frame(0, 9'h03C, 8, 1'b1, 1'b0, 1, 1'b1);
        idle_bits(1);
        total++; if (q0.size() !== 2) begin bad++; $display("FAIL perr_clear_count got=%0d want=2", q0.size()); end
        total++; if (bus0.oData !== 8'h3C) begin bad++; $display("FAIL perr_clear_data got=%h want=3c", bus0.oData); end
        total++; if (bus0.oParityErr !== 1'b0) begin bad++; $display("FAIL perr_clear_flag got=%b want=0", bus0.oParityErr); end
    endtask

    task automatic test_break();
        q0.delete();
        send_frame(0, 9'h055, 8, 1'b1, 1'b0, 1, 1'b0);
        idle_bits(40);
        total++; if (q0.size() !== 1) begin bad++; $display("FAIL break_count got=%0d want=1", q0.size()); end
        if (q0.size() > 0) begin
            total++; if (q0[0].data !== 9'h055) begin bad++; $display("FAIL break_data got=%h want=055", q0[0].data); end
            total++; if (q0[0].ferr !== 1'b1) begin bad++; $display("FAIL break_ferr got=%b want=1", q0[0].ferr); end
            total++; if (q0[0].perr !== 1'b0) begin bad++; $display("FAIL break_perr got=%b want=0", q0[0].perr); end
        end
        total++; if (bus0.oBusy !== 1'b0) begin bad++; $display("FAIL break_busy got=%b want=0", bus0.oBusy); end
        rx_line[0] = 1'b1;
        idle_bits(2);
        send_frame(0, 9'h012, 8, 1'b1, 1'b0, 1, 1'b1);
        idle_bits(1);
        total++; if (q0.size() !== 2) begin bad++; $display("FAIL break_recover_count got=%0d want=2", q0.size()); end
        if (q0.size() > 1) begin
            total++; if (q0[1].data !== 9'h012) begin bad++; $display("FAIL break_recover_data got=%h want=012", q0[1].data); end
            total++; if (q0[1].ferr !== 1'b0) begin bad++; $display("FAIL break_recover_ferr got=%b want=0", q0[1].ferr); end
        end
    endtask

    task automatic test_glitch();
        bit idle_seen;
        q0.delete();
        rx_line[0] = 1'b0;
        repeat (4) @(posedge iClk);
        #1;
        rx_line[0] = 1'b1;
        @(negedge iClk);
        total++; if (bus0.oBusy !== 1'b1) begin bad++; $display("FAIL glitch_busy_rise got=%b want=1", bus0.oBusy); end
        idle_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge iClk);
            if (bus0.oBusy === 1'b0) begin
                idle_seen = 1'b1;
                break;
            end
        end
        total++; if (idle_seen !== 1'b1) begin bad++; $display("FAIL glitch_busy_fall got=%b want=0 within 10 cycles", bus0.oBusy); end
        @(posedge iClk); #1;
        idle_bits(3);
        total++; if (q0.size() !== 0) begin bad++; $display("FAIL glitch_no_valid got=%0d want=0", q0.size()); end
        send_frame(0, 9'h07E, 8, 1'b1, 1'b0, 1, 1'b1);
        idle_bits(1);
        total++; if (q0.size() !== 1) begin bad++; $display("FAIL glitch_next_count got=%0d want=1", q0.size()); end
        if (q0.size() > 0) begin
            total++; if (q0[0].data !== 9'h07E) begin bad++; $display("FAIL glitch_next_data got=%h want=07e", q0[0].data); end
        end
    endtask

    task automatic test_back_to_back();
        q0.delete();
        send_frame(0, 9'h000, 8, 1'b1, 1'b0, 1, 1'b1);
        send_frame(0, 9'h0FF, 8, 1'b1, 1'b0, 1, 1'b1);
        send_frame(0, 9'h081, 8, 1'b1, 1'b0, 1, 1'b1);
        idle_bits(2);
        total++; if (q0.size() !== 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", q0.size()); end
        if (q0.size() > 2) begin
            total++; if (q0[0].data !== 9'h000) begin bad++; $display("FAIL b2b_word0 got=%h want=000", q0[0].data); end
            total++; if (q0[1].data !== 9'h0FF) begin bad++; $display("FAIL b2b_word1 got=%h want=0ff", q0[1].data); end
            total++; if (q0[2].data !== 9'h081) begin bad++; $display("FAIL b2b_word2 got=%h want=081", q0[2].data); end
            total++; if ((q0[0].perr | q0[1].perr | q0[2].perr | q0[0].ferr | q0[1].ferr | q0[2].ferr) !== 1'b0) begin
                bad++; $display("FAIL b2b_errs got=1 want=0");
            end
        end
    endtask

    task automatic test_sweep_7n2();
        int lat;
        q1.delete();
        send_frame(1, 9'h05A, 7, 1'b0, 1'b0, 2, 1'b1);
        idle_bits(1);
        total++; if (q1.size() !== 1) begin bad++; $display("FAIL n72_count got=%0d want=1", q1.size()); end
        if (q1.size() > 0) begin
            total++; if (q1[0].data !== 9'h05A) begin bad++; $display("FAIL n72_data got=%h want=05a", q1[0].data); end
            total++; if ((q1[0].perr | q1[0].ferr) !== 1'b0) begin bad++; $display("FAIL n72_errs got=%b%b want=00", q1[0].perr, q1[0].ferr); end
            lat = q1[0].cyc - start_cyc;
            total++; if (lat < LAT1 - 1 || lat > LAT1 + 1) begin bad++; $display("FAIL n72_latency got=%0d want=%0d+-1", lat, LAT1); end
        end
        // First stop high, second stop low: the framing error must come from
        // the final stop sample alone.
        send_frame(1, 9'h025, 7, 1'b0, 1'b0, 2, 1'b0);
        idle_bits(1);
        total++; if (q1.size() !== 2) begin bad++; $display("FAIL n72_stop2_count got=%0d want=2", q1.size()); end
        if (q1.size() > 1) begin
            total++; if (q1[1].data !== 9'h025) begin bad++; $display("FAIL n72_stop2_data got=%h want=025", q1[1].data); end
            total++; if (q1[1].ferr !== 1'b1) begin bad++; $display("FAIL n72_stop2_ferr got=%b want=1", q1[1].ferr); end
        end
        rx_line[1] = 1'b1;
        idle_bits(2);
    endtask

    task automatic test_sweep_odd();
        q2.delete();
        send_frame(2, 9'h05A, 8, 1'b1, 1'b1, 1, 1'b1);
        idle_bits(1);
        send_frame(2, 9'h05A, 8, 1'b1, 1'b0, 1, 1'b1);
        idle_bits(1);
        total++; if (q2.size() !== 2) begin bad++; $display("FAIL odd_count got=%0d want=2", q2.size()); end
        if (q2.size() > 1) begin
            total++; if (q2[0].data !== 9'h05A) begin bad++; $display("FAIL odd_data got=%h want=05a", q2[0].data); end
            total++; if (q2[0].perr !== 1'b0) begin bad++; $display("FAIL odd_good_perr got=%b want=0", q2[0].perr); end
            total++; if (q2[1].perr !== 1'b1) begin bad++; $display("FAIL odd_bad_perr got=%b want=1", q2[1].perr); end
        end
    endtask

    task automatic test_reset_mid();
        q0.delete();
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        rx_line[0] = 1'b1;
        repeat (HALF) @(posedge iClk);
        #1;
        iRst = 1'b1;
        @(negedge iClk);
        total++; if (bus0.oData !== 8'h00) begin bad++; $display("FAIL rstmid_data got=%h want=00", bus0.oData); end
        total++; if ({bus0.oValid, bus0.oParityErr, bus0.oFrameErr, bus0.oBusy} !== 4'b0000) begin
            bad++; $display("FAIL rstmid_flags got=%b want=0000", {bus0.oValid, bus0.oParityErr, bus0.oFrameErr, bus0.oBusy});
        end
        repeat (3) @(posedge iClk);
        #1;
        iRst = 1'b0;
        idle_bits(3);
        total++; if (q0.size() !== 0) begin bad++; $display("FAIL rstmid_no_valid got=%0d want=0", q0.size()); end
        send_frame(0, 9'h0C3, 8, 1'b1, 1'b0, 1, 1'b1);
        idle_bits(1);
        total++; if (q0.size() !== 1) begin bad++; $display("FAIL rstmid_next_count got=%0d want=1", q0.size()); end
        if (q0.size() > 0) begin
            total++; if (q0[0].data !== 9'h0C3) begin bad++; $display("FAIL rstmid_next_data got=%h want=0c3", q0[0].data); end
            total++; if ((q0[0].perr | q0[0].ferr) !== 1'b0) begin bad++; $display("FAIL rstmid_next_errs got=%b%b want=00", q0[0].perr, q0[0].ferr); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity_err();
        test_break();
        test_glitch();
        test_back_to_back();
        test_sweep_7n2();
        test_sweep_odd();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
